// File: rtl/fetch_queue_unit_pkg.sv
// Shared types for the fetch queue unit: instruction word, immediate, FSM state.
package fetch_queue_unit_pkg;

    localparam int INSTR_W = 32;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [11:0]        imm_t;

    // RUN issues fetches; HALTED waits for a redirect after a faulting issue.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // A fetch address must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// DEPTH-entry FIFO with push, pop, flush and occupancy count. Pointers carry
// one extra wrap bit so full and empty are distinguishable.
module fetch_queue #(
    parameter int W     = 65,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [PW:0]   count_o,
    output logic          empty_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wptr_q, wptr_d;
    logic [PW:0]  rptr_q, rptr_d;
    logic         full;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full    = (wptr_q[PW] != rptr_q[PW]) &&
                     (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    // Flush dominates: nothing is written or consumed on a flushing edge.
    assign do_push = push_i && !full && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign count_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[PW-1:0]];

    // Pointer next-state: flush empties the queue, otherwise advance per op.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_queue_unit_imem.sv
// Instruction memory: MEM_SIZE x 32-bit words, one-cycle synchronous read.
// Contents are normally loaded hierarchically through the M array; the write
// port exists for a future loader and is tied off by the fetch unit.
module fetch_queue_unit_imem
    import fetch_queue_unit_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int IW       = $clog2(MEM_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  instr_t        wdata_i,
    output instr_t        rdata_o
);

    instr_t M [MEM_SIZE];
    instr_t rdata_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            M[waddr_i] <= wdata_i;
        end
    end

    // Registered read; cleared on reset so no stale word is ever visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= M[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: issues one read per cycle into a synchronous instruction
// memory, queues {pc, instr, fault} entries for decode behind a valid/ready
// handshake, flushes on redirect and halts after issuing a faulting address.
//
// Handshake: the head entry transfers at a rising edge where out__valid and
// out__ready are both high; while out__valid is high and out__ready low the
// out__* signals hold. A redirect in the same edge discards that transfer.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int              MEM_SIZE = 1024,
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect__valid,
    input  logic [ADDR_W-1:0] redirect__target,
    output logic              out__valid,
    input  logic              out__ready,
    output logic [ADDR_W-1:0] out__pc,
    output instr_t            out__instr,
    output logic              out__fault,
    output logic [ADDR_W-1:0] pc_cur,
    output logic              halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(MEM_SIZE);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        instr_t            instr;
        logic              fault;
    } fetch_entry_t;

    localparam int EW = $bits(fetch_entry_t);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              infl_fault_q, infl_fault_d;

    logic [PW:0]       q_count;
    logic              q_empty;
    logic [EW-1:0]     q_head_raw;
    fetch_entry_t      q_head;
    fetch_entry_t      push_entry;
    logic [PW+1:0]     occupancy;
    logic              room;
    logic              issue;
    logic              issue_fault;
    logic              push;
    logic              pop;
    logic              mem_re;
    instr_t            mem_rdata;

    // Queue entries plus the read in flight must never exceed DEPTH.
    assign occupancy   = {1'b0, q_count} + {{(PW+1){1'b0}}, infl_q};
    assign room        = occupancy < (PW+2)'(DEPTH);
    assign issue_fault = is_misaligned(pc_q[1:0]) ||
                         ((pc_q >> 2) >= ADDR_W'(MEM_SIZE));
    assign issue       = (state_q == ST_RUN) && !redirect__valid && room;
    assign push        = infl_q && !redirect__valid;
    assign pop         = !q_empty && out__ready && !redirect__valid;
    // Faulting addresses never touch the array.
    assign mem_re      = issue && !issue_fault;

    assign push_entry.pc    = infl_pc_q;
    assign push_entry.instr = infl_fault_q ? '0 : mem_rdata;
    assign push_entry.fault = infl_fault_q;

    assign q_head = fetch_entry_t'(q_head_raw);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // FSM next state: redirect restarts fetch, a faulting issue stops it.
    always_comb begin
        state_d = state_q;
        if (redirect__valid) begin
            state_d = ST_RUN;
        end else if (issue && issue_fault) begin
            state_d = ST_HALTED;
        end
    end

    // FSM outputs.
    always_comb begin
        halted = (state_q == ST_HALTED);
    end

    // Datapath next state: fetch address and the in-flight read tag.
    always_comb begin
        pc_d         = pc_q;
        infl_d       = 1'b0;
        infl_pc_d    = infl_pc_q;
        infl_fault_d = infl_fault_q;
        if (redirect__valid) begin
            pc_d = redirect__target;
        end else if (issue) begin
            pc_d         = pc_q + ADDR_W'(4);
            infl_d       = 1'b1;
            infl_pc_d    = pc_q;
            infl_fault_d = issue_fault;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            infl_q       <= 1'b0;
            infl_pc_q    <= '0;
            infl_fault_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            infl_q       <= infl_d;
            infl_pc_q    <= infl_pc_d;
            infl_fault_q <= infl_fault_d;
        end
    end

    fetch_queue_unit_imem #(
        .MEM_SIZE (MEM_SIZE)
    ) instruction_memory (
        .clk     (clk),
        .reset   (reset),
        .re_i    (mem_re),
        .raddr_i (pc_q[IW+1:2]),
        .we_i    (1'b0),
        .waddr_i ('0),
        .wdata_i ('0),
        .rdata_o (mem_rdata)
    );

    fetch_queue #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect__valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (q_head_raw),
        .count_o     (q_count),
        .empty_o     (q_empty)
    );

    // Decode-facing outputs are zero whenever nothing is queued.
    assign out__valid = !q_empty;
    assign out__pc    = q_empty ? '0 : q_head.pc;
    assign out__instr = q_empty ? '0 : q_head.instr;
    assign out__fault = q_empty ? 1'b0 : q_head.fault;
    assign pc_cur     = pc_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios followed by random traffic,
// compared every cycle against a queue-level reference model.
module tb_fetch_queue_unit;

    localparam int          MEM_SIZE = 1024;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect__valid;
    logic [31:0] redirect__target;
    logic        out__valid;
    logic        out__ready;
    logic [31:0] out__pc;
    logic [31:0] out__instr;
    logic        out__fault;
    logic [31:0] pc_cur;
    logic        halted;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .MEM_SIZE (MEM_SIZE),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect__valid  (redirect__valid),
        .redirect__target (redirect__target),
        .out__valid       (out__valid),
        .out__ready       (out__ready),
        .out__pc          (out__pc),
        .out__instr       (out__instr),
        .out__fault       (out__fault),
        .pc_cur           (pc_cur),
        .halted           (halted)
    );

    // ---------------- reference model ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem_img [MEM_SIZE];
    logic [64:0] exp_q [$];     // {pc, instr, fault}, head at index 0
    logic [31:0] m_pc;
    logic        m_infl;
    logic [64:0] m_infl_e;
    logic        m_halt;

    function automatic logic [64:0] make_entry(input logic [31:0] pc);
        logic        f;
        logic [31:0] w;
        f = (pc[1:0] != 2'b00) || ((pc >> 2) >= 32'(MEM_SIZE));
        w = 32'h0;
        if (!f) w = mem_img[pc[11:2]];
        return {pc, w, f};
    endfunction

    // One rising edge of the behaviour described for the fetch unit.
    task automatic model_step();
        logic room;
        logic do_pop;
        logic do_issue;
        if (!reset) begin
            exp_q.delete();
            m_pc   = RESET_PC;
            m_infl = 1'b0;
            m_halt = 1'b0;
        end else if (redirect__valid) begin
            exp_q.delete();
            m_pc   = redirect__target;
            m_infl = 1'b0;
            m_halt = 1'b0;
        end else begin
            room     = (exp_q.size() + (m_infl ? 1 : 0)) < DEPTH;
            do_pop   = (exp_q.size() != 0) && out__ready;
            do_issue = !m_halt && room;
            if (do_pop) void'(exp_q.pop_front());
            if (m_infl) exp_q.push_back(m_infl_e);
            m_infl = 1'b0;
            if (do_issue) begin
                m_infl_e = make_entry(m_pc);
                m_infl   = 1'b1;
                if (m_infl_e[0]) m_halt = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out__valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_pc",    64'(out__pc),    64'(exp_q[0][64:33]));
            chk("out_instr", 64'(out__instr), 64'(exp_q[0][32:1]));
            chk("out_fault", 64'(out__fault), 64'(exp_q[0][0]));
        end
        chk("pc_cur", 64'(pc_cur), 64'(m_pc));
        chk("halted", 64'(halted), 64'(m_halt));
    endtask

    // ---------------- driver ----------------
    // Inputs change only at the falling edge; outputs are checked there too.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect__valid  = 1'b1;
        redirect__target = tgt;
        cycle();
        redirect__valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        reset            = 1'b0;
        redirect__valid  = 1'b0;
        redirect__target = 32'h0;
        out__ready       = 1'b1;
        m_pc             = RESET_PC;
        m_infl           = 1'b0;
        m_infl_e         = '0;
        m_halt           = 1'b0;

        for (int i = 0; i < MEM_SIZE; i++) begin
            v = $urandom;
            if (i == 64) v = 32'hdead_beef;
            mem_img[i] = v;
            dut.instruction_memory.M[i] = v;
        end

        @(negedge clk);
        cycle();
        cycle();
        chk("rst_valid", 64'(out__valid), 64'(0));
        chk("rst_pc",    64'(out__pc),    64'(0));
        chk("rst_instr", 64'(out__instr), 64'(0));
        chk("rst_fault", 64'(out__fault), 64'(0));
        chk("rst_pc_cur", 64'(pc_cur),    64'(RESET_PC));
        chk("rst_halted", 64'(halted),    64'(0));

        // 1: streaming from reset with decode always ready
        reset = 1'b1;
        cycle();
        chk("t1_edge1_valid", 64'(out__valid), 64'(0));
        cycle();
        chk("t1_edge2_valid", 64'(out__valid), 64'(1));
        for (int k = 0; k < 4; k++) begin
            chk("t1_pc",    64'(out__pc),    64'(4 * k));
            chk("t1_instr", 64'(out__instr), 64'(mem_img[k]));
            cycle();
        end

        // 2: backpressure from reset fills exactly DEPTH entries
        reset = 1'b0;
        cycle();
        reset      = 1'b1;
        out__ready = 1'b0;
        repeat (10) cycle();
        chk("t2_pc_cur", 64'(pc_cur),  64'(32'h10));
        chk("t2_head",   64'(out__pc), 64'(0));
        out__ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t2_drain_valid", 64'(out__valid), 64'(1));
            chk("t2_drain_pc",    64'(out__pc),    64'(4 * k));
            cycle();
        end

        // 3: redirect while the queue is full
        out__ready = 1'b0;
        repeat (6) cycle();
        do_redirect(32'h100);
        chk("t3_r0_valid", 64'(out__valid), 64'(0));
        cycle();
        chk("t3_r1_valid", 64'(out__valid), 64'(0));
        cycle();
        chk("t3_r2_valid", 64'(out__valid), 64'(1));
        chk("t3_r2_pc",    64'(out__pc),    64'(32'h100));
        chk("t3_r2_instr", 64'(out__instr), 64'(32'hdead_beef));

        // 4: fetch runs off the end of memory
        out__ready = 1'b1;
        do_redirect(32'hffc);
        cycle();
        cycle();
        chk("t4_last_pc",    64'(out__pc),    64'(32'hffc));
        chk("t4_last_instr", 64'(out__instr), 64'(mem_img[1023]));
        cycle();
        chk("t4_oor_pc",    64'(out__pc),    64'(32'h1000));
        chk("t4_oor_fault", 64'(out__fault), 64'(1));
        chk("t4_oor_instr", 64'(out__instr), 64'(0));
        repeat (4) cycle();
        chk("t4_halted", 64'(halted), 64'(1));
        chk("t4_pc_cur", 64'(pc_cur), 64'(32'h1004));

        // 5: misaligned target faults, redirect recovers
        out__ready = 1'b0;
        do_redirect(32'h2203);
        repeat (4) cycle();
        chk("t5_halted",   64'(halted),     64'(1));
        chk("t5_fault",    64'(out__fault), 64'(1));
        out__ready = 1'b1;
        do_redirect(32'h8);
        chk("t5_unhalted", 64'(halted), 64'(0));
        cycle();
        cycle();
        chk("t5_resume_pc",    64'(out__pc),    64'(32'h8));
        chk("t5_resume_instr", 64'(out__instr), 64'(mem_img[2]));

        // 6: one-edge reset in the middle of a stream
        repeat (5) begin
            out__ready = 1'($urandom_range(0, 1));
            cycle();
        end
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("t6_valid",  64'(out__valid), 64'(0));
        chk("t6_pc_cur", 64'(pc_cur),     64'(RESET_PC));
        repeat (3) cycle();

        // random traffic: ready, redirects (in range, near end, misaligned,
        // far out of range) and occasional resets
        repeat (600) begin
            int r;
            out__ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect__valid = 1'b1;
                r = $urandom_range(0, 9);
                if (r < 6)       redirect__target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                else if (r < 8)  redirect__target = 32'hff0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
                else if (r == 8) redirect__target = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
                else             redirect__target = $urandom | 32'h0001_0000;
            end else begin
                redirect__valid = 1'b0;
            end
            reset = ($urandom_range(0, 63) != 0);
            cycle();
        end
        redirect__valid = 1'b0;
        reset           = 1'b1;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
